// File: rtl/kernel_nios2_qsys_0_mul_seq.sv
// kernel_nios2_qsys_0_mul_seq
// Sequential multiplier front-end around an external 32x32 -> low-32 multiply cell.
// MUL takes one pass through the cell. The high-word ops (MULXUU/MULXSU/MULXSS)
// take four 16x16 passes that are summed into a 64-bit accumulator.
// Optional feature macro: KERNEL_NIOS2_QSYS_0_MUL_SEQ_SIGNED_EN
//   defined   : MULXSU / MULXSS subtract a signed correction from the unsigned high word
//   undefined : no correction logic; ops 10 and 11 behave as MULXUU
module kernel_nios2_qsys_0_mul_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic [31:0] A_mul_src1,
   output logic [31:0] A_mul_src2,
   input  logic [31:0] A_mul_cell_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_LAST  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSU = 2'b10;
   localparam logic [1:0] OP_MULXSS = 2'b11;

   // Select the zero-extended upper or lower 16-bit half of an operand.
   function automatic logic [31:0] half_sel(input logic [31:0] v, input logic hi);
      logic [31:0] h;
      if (hi) begin
         h = {16'h0000, v[31:16]};
      end else begin
         h = {16'h0000, v[15:0]};
      end
      return h;
   endfunction

   state_t      state_r, state_s;
   logic [1:0]  pass_r, pass_s, pass_inc_s, add_idx_s;
   logic [1:0]  op_r, op_s;
   logic [31:0] src1_r, src1_s, src2_r, src2_s;
   logic [63:0] acc_r, acc_s, pp_s, sum_s;
   logic [31:0] a_src1_r, a_src1_s, a_src2_r, a_src2_s;
   logic        rsp_valid_r, rsp_valid_s;
   logic [31:0] rsp_data_r, rsp_data_s;
   logic [31:0] corr_s;
   logic        handshake_s;

`ifdef KERNEL_NIOS2_QSYS_0_MUL_SEQ_SIGNED_EN
   // Amount to subtract from the unsigned high word to get the signed high word.
   function automatic logic [31:0] high_corr(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] c;
      c = 32'h0000_0000;
      case (op)
         OP_MULXSU: c = a[31] ? b : 32'h0000_0000;
         OP_MULXSS: c = (a[31] ? b : 32'h0000_0000) + (b[31] ? a : 32'h0000_0000);
         default:   c = 32'h0000_0000;
      endcase
      return c;
   endfunction

   assign corr_s = high_corr(op_r, src1_r, src2_r);
`else
   assign corr_s = 32'h0000_0000;
`endif

   // Accepting only in IDLE and never while reset is asserted.
   assign req_ready   = (state_r == ST_IDLE) && !reset;
   assign handshake_s = req_valid && req_ready;

   assign A_mul_src1 = a_src1_r;
   assign A_mul_src2 = a_src2_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_data   = rsp_data_r;

   assign pass_inc_s = pass_r + 2'd1;

   // Position the cell result of the pass currently returning (the previous pass).
   always_comb begin
      pp_s = 64'h0;
      if (state_r == ST_LAST) begin
         add_idx_s = 2'd3;
      end else begin
         add_idx_s = pass_r - 2'd1;
      end
      case (add_idx_s)
         2'd0:    pp_s = {32'h0000_0000, A_mul_cell_result};
         2'd1:    pp_s = {16'h0000, A_mul_cell_result, 16'h0000};
         2'd2:    pp_s = {16'h0000, A_mul_cell_result, 16'h0000};
         2'd3:    pp_s = {A_mul_cell_result, 32'h0000_0000};
         default: pp_s = 64'h0;
      endcase
      sum_s = acc_r + pp_s;
   end

   // Next-state and next-datapath logic for the sequencer.
   always_comb begin
      state_s     = state_r;
      pass_s      = pass_r;
      op_s        = op_r;
      src1_s      = src1_r;
      src2_s      = src2_r;
      acc_s       = acc_r;
      a_src1_s    = 32'h0000_0000;
      a_src2_s    = 32'h0000_0000;
      rsp_valid_s = rsp_valid_r;
      rsp_data_s  = rsp_data_r;
      case (state_r)
         ST_IDLE: begin
            if (handshake_s) begin
               op_s    = req_op;
               src1_s  = req_src1;
               src2_s  = req_src2;
               acc_s   = 64'h0;
               pass_s  = 2'd0;
               state_s = ST_ISSUE;
               if (req_op == OP_MUL) begin
                  a_src1_s = req_src1;
                  a_src2_s = req_src2;
               end else begin
                  a_src1_s = half_sel(req_src1, 1'b0);
                  a_src2_s = half_sel(req_src2, 1'b0);
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // From the second pass on, the cell is returning the previous pass.
            if ((op_r != OP_MUL) && (pass_r != 2'd0)) begin
               acc_s = sum_s;
            end else begin
               acc_s = acc_r;
            end
            if ((op_r == OP_MUL) || (pass_r == 2'd3)) begin
               state_s = ST_LAST;
               pass_s  = 2'd0;
            end else begin
               pass_s   = pass_inc_s;
               a_src1_s = half_sel(src1_r, pass_inc_s[0]);
               a_src2_s = half_sel(src2_r, pass_inc_s[1]);
            end
         end
         ST_LAST: begin
            if (op_r == OP_MUL) begin
               rsp_data_s = A_mul_cell_result;
            end else begin
               acc_s      = sum_s;
               rsp_data_s = sum_s[63:32] - corr_s;
            end
            rsp_valid_s = 1'b1;
            state_s     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_s = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               rsp_valid_s = 1'b1;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            rsp_valid_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         pass_r      <= 2'd0;
         op_r        <= 2'b00;
         src1_r      <= 32'h0000_0000;
         src2_r      <= 32'h0000_0000;
         acc_r       <= 64'h0;
         a_src1_r    <= 32'h0000_0000;
         a_src2_r    <= 32'h0000_0000;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= 32'h0000_0000;
      end else begin
         state_r     <= state_s;
         pass_r      <= pass_s;
         op_r        <= op_s;
         src1_r      <= src1_s;
         src2_r      <= src2_s;
         acc_r       <= acc_s;
         a_src1_r    <= a_src1_s;
         a_src2_r    <= a_src2_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_data_r  <= rsp_data_s;
      end
   end

endmodule

// File: tb/tb_kernel_nios2_qsys_0_mul_seq.sv
// Testbench for kernel_nios2_qsys_0_mul_seq: behavioural multiply cell,
// scoreboard of expected results, directed steps in one initial block.
module tb_kernel_nios2_qsys_0_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_src1, req_src2;
   logic [31:0] A_mul_src1, A_mul_src2;
   logic [31:0] A_mul_cell_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] sb[$];

   kernel_nios2_qsys_0_mul_seq dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2),
      .A_mul_src1(A_mul_src1), .A_mul_src2(A_mul_src2),
      .A_mul_cell_result(A_mul_cell_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   // Multiply cell: low 32 bits of the product, one clock after the operands.
   always @(posedge clk) A_mul_cell_result <= A_mul_src1 * A_mul_src2;

   // Reference result computed from full-width 64-bit products.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] x, y, p;
      x = {32'h0, a};
      y = {32'h0, b};
`ifdef KERNEL_NIOS2_QSYS_0_MUL_SEQ_SIGNED_EN
      if (op[1]) x = {{32{a[31]}}, a};
      if (op == 2'b11) y = {{32{b[31]}}, b};
`endif
      p = x * y;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer a request at the current negedge; returns at the negedge of T+1.
   task automatic send(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
      #1;
      chk({tag, "_req_ready"}, {63'h0, req_ready}, 64'd1);
      sb.push_back(model(op, a, b));
      @(negedge clk);
      req_valid = 1'b0; req_op = ~op; req_src1 = ~a; req_src2 = b ^ 32'h5A5A_5A5A;
   endtask

   // Wait for rsp_valid from cycle lat0 on; check latency, data and pulse width.
   task automatic wait_rsp(input string tag, input int lat0, input int exp_lat);
      int lat;
      logic seen;
      logic [31:0] e;
      lat = lat0;
      seen = 1'b0;
      while (!seen && lat < 30) begin
         if (rsp_valid === 1'b1) seen = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      chk({tag, "_seen"}, {63'h0, seen}, 64'd1);
      if (seen) begin
         chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
         chk({tag, "_sb_nonempty"}, {63'h0, (sb.size() != 0)}, 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, {32'h0, rsp_data}, {32'h0, e});
         end
         @(negedge clk);
         chk({tag, "_pulse"}, {63'h0, rsp_valid}, 64'd0);
      end
   endtask

   initial begin
      logic [31:0] d0;
      reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_src1 = 32'h0; req_src2 = 32'h0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready_low", {63'h0, req_ready}, 64'd0);
      reset = 1'b0;
      #1;
      chk("rst_ready_high", {63'h0, req_ready}, 64'd1);
      chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'd0);
      chk("rst_rsp_data", {32'h0, rsp_data}, 64'd0);
      chk("rst_src", {A_mul_src1, A_mul_src2}, 64'd0);
      @(negedge clk);

      // MUL single pass: operands at T+1, result at T+3
      send("mul", 2'b00, 32'h0001_0003, 32'h0002_0005);
      chk("mul_src_t1", {A_mul_src1, A_mul_src2}, {32'h0001_0003, 32'h0002_0005});
      chk("mul_const", {32'h0, model(2'b00, 32'h0001_0003, 32'h0002_0005)}, 64'h0000_0000_000B_000F);
      wait_rsp("mul", 1, 3);
      chk("idle_src", {A_mul_src1, A_mul_src2}, 64'd0);

      // MULXUU all-ones: four half passes at T+1..T+4
      send("xuu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int p = 0; p < 4; p++) begin
         chk("xuu_half", {A_mul_src1, A_mul_src2}, {32'h0000_FFFF, 32'h0000_FFFF});
         @(negedge clk);
      end
      chk("xuu_src_last", {A_mul_src1, A_mul_src2}, 64'd0);
      wait_rsp("xuu_ff", 5, 6);

      // Distinct halves expose pass ordering
      send("xuu_pat", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      chk("pat_p0", {A_mul_src1, A_mul_src2}, {32'h0000_5678, 32'h0000_DEF0});
      @(negedge clk);
      chk("pat_p1", {A_mul_src1, A_mul_src2}, {32'h0000_1234, 32'h0000_DEF0});
      @(negedge clk);
      chk("pat_p2", {A_mul_src1, A_mul_src2}, {32'h0000_5678, 32'h0000_9ABC});
      @(negedge clk);
      chk("pat_p3", {A_mul_src1, A_mul_src2}, {32'h0000_1234, 32'h0000_9ABC});
      @(negedge clk);
      wait_rsp("xuu_pat", 5, 6);

      // Signed variants (result depends on build)
      send("xss_m1x2", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002);
      wait_rsp("xss_m1x2", 1, 6);
      send("xsu_8x8", 2'b10, 32'h8000_0000, 32'h8000_0000);
      wait_rsp("xsu_8x8", 1, 6);
      send("xss_mix", 2'b11, 32'h8000_0000, 32'h7FFF_FFFF);
      wait_rsp("xss_mix", 1, 6);
      send("xss_neg", 2'b11, 32'hFEDC_BA98, 32'h8765_4321);
      wait_rsp("xss_neg", 1, 6);
      send("mul_rand", 2'b00, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      wait_rsp("mul_rand", 1, 3);

      // Backpressure: response held for 5 cycles, new request waits
      rsp_ready = 1'b0;
      send("bp", 2'b00, 32'h0000_0013, 32'h0000_0017);
      @(negedge clk);
      @(negedge clk);
      chk("bp_valid", {63'h0, rsp_valid}, 64'd1);
      d0 = rsp_data;
      chk("bp_sb_nonempty", {63'h0, (sb.size() != 0)}, 64'd1);
      if (sb.size() != 0) chk("bp_data", {32'h0, rsp_data}, {32'h0, sb.pop_front()});
      req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'h0000_0007; req_src2 = 32'h0000_0009;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", {63'h0, rsp_valid}, 64'd1);
         chk("bp_hold_data", {32'h0, rsp_data}, {32'h0, d0});
         chk("bp_hold_ready", {63'h0, req_ready}, 64'd0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_same_cycle", {63'h0, req_ready}, 64'd0);
      @(negedge clk);
      chk("bp_released", {63'h0, rsp_valid}, 64'd0);
      send("bp_next", 2'b00, 32'h0000_0007, 32'h0000_0009);
      wait_rsp("bp_next", 1, 3);

      // Reset during a high op at T+3 abandons it
      send("rst_mid", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_ready", {63'h0, req_ready}, 64'd1);
      chk("mid_data", {32'h0, rsp_data}, 64'd0);
      chk("mid_src", {A_mul_src1, A_mul_src2}, 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk("mid_no_valid", {63'h0, rsp_valid}, 64'd0);
         @(negedge clk);
      end
      send("after_rst", 2'b00, 32'h0000_0003, 32'h0000_0005);
      wait_rsp("after_rst", 1, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
